// File: rtl/usr_shift_controller_pkg.sv
// -----------------------------------------------------------------------------
// usr_shift_controller_pkg
// Shared definitions for the universal-shift-register command sequencer:
//   - command opcode encodings (ROR / SLL / PASS / CLEAR)
//   - shift-register mode select constants (HOLD / ROTR / SHL / LOAD)
//   - sequencer FSM state encoding
//   - helper mapping a shift opcode to the register mode that performs it
// -----------------------------------------------------------------------------
package usr_shift_controller_pkg;

    // Command opcodes as presented on cmd_op
    localparam logic [1:0] OP_ROR   = 2'b00;
    localparam logic [1:0] OP_SLL   = 2'b01;
    localparam logic [1:0] OP_PASS  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Mode select values understood by the universal shift register
    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_ROTR = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CLR   = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Register mode that applies one step of the given shift opcode.
    // Non-shift opcodes map to HOLD so a stray call can never disturb the register.
    function automatic logic [1:0] shift_mode(input logic [1:0] op);
        logic [1:0] mode;
        case (op)
            OP_ROR:  mode = USR_ROTR;
            OP_SLL:  mode = USR_SHL;
            default: mode = USR_HOLD;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/usr_shift_cmd_buf.sv
// -----------------------------------------------------------------------------
// usr_shift_cmd_buf
// One-entry command buffer used when USR_SHIFT_CTRL_CMD_BUF_EN is defined.
// Holds op/amt/data of a command accepted while the sequencer is busy.
// A write and a read on the same edge leave the buffer full with the new entry.
// Ports:
//   clk, Rst_n        clock, asynchronous active-low reset (clears full)
//   wr_en             store wr_op/wr_amt/wr_data
//   rd_en             consume the stored entry
//   wr_op/amt/data    entry to store
//   full              entry present
//   rd_op/amt/data    stored entry (registered)
// -----------------------------------------------------------------------------
module usr_shift_cmd_buf #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [1:0]       wr_op,
    input  logic [AMT_W-1:0] wr_amt,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic [1:0]       rd_op,
    output logic [AMT_W-1:0] rd_amt,
    output logic [WIDTH-1:0] rd_data
);

    logic             full_r;
    logic [1:0]       op_r;
    logic [AMT_W-1:0] amt_r;
    logic [WIDTH-1:0] data_r;

    // Entry storage and occupancy; a write wins over a simultaneous read
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            full_r <= 1'b0;
            op_r   <= 2'b00;
            amt_r  <= '0;
            data_r <= '0;
        end else if (wr_en) begin
            full_r <= 1'b1;
            op_r   <= wr_op;
            amt_r  <= wr_amt;
            data_r <= wr_data;
        end else if (rd_en) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign full    = full_r;
    assign rd_op   = op_r;
    assign rd_amt  = amt_r;
    assign rd_data = data_r;

endmodule

// File: rtl/usr_shift_controller.sv
// -----------------------------------------------------------------------------
// usr_shift_controller
// Command sequencer for an external universal shift register. Each accepted
// command parallel-loads its operand, applies cmd_amt rotate/shift steps (or a
// single synchronous clear) and returns the register contents on a
// valid/ready response channel.
//
// Optional build macro: USR_SHIFT_CTRL_CMD_BUF_EN
//   Adds a one-entry command buffer so a new command may be accepted while a
//   previous one is in flight; the buffered command launches on the response
//   handshake edge, skipping IDLE. cmd_ready is then ~buffer_full.
//
// Ports:
//   clk, Rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op/cmd_amt/cmd_data    opcode, step count, operand
//   usr_sel/usr_datain/usr_clr mode select, load value, sync clear (registered)
//   usr_dataout                shift register contents
//   rsp_valid/rsp_ready        response handshake
//   rsp_data                   result (shift register contents)
// -----------------------------------------------------------------------------
module usr_shift_controller
    import usr_shift_controller_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       usr_sel,
    output logic [WIDTH-1:0] usr_datain,
    output logic             usr_clr,
    input  logic [WIDTH-1:0] usr_dataout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);

    localparam logic [AMT_W-1:0] CNT_ZERO = '0;
    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

    state_e           state_r;
    logic [AMT_W-1:0] cnt_r;
    logic [1:0]       op_r;
    logic [AMT_W-1:0] amt_r;
    logic [WIDTH-1:0] data_r;
    logic [1:0]       usr_sel_r;
    logic             usr_clr_r;
    logic             rsp_valid_r;

    // Command launch: when a command starts this edge, and where it comes from
    logic             start_s;
    logic [1:0]       src_op_s;
    logic [AMT_W-1:0] src_amt_s;
    logic [WIDTH-1:0] src_data_s;

    // First state/outputs of a launched command
    state_e           launch_state_s;
    logic [1:0]       launch_sel_s;
    logic             launch_clr_s;

`ifdef USR_SHIFT_CTRL_CMD_BUF_EN
    logic             buf_full_s;
    logic             buf_wr_s;
    logic             buf_rd_s;
    logic [1:0]       buf_op_s;
    logic [AMT_W-1:0] buf_amt_s;
    logic [WIDTH-1:0] buf_data_s;

    usr_shift_cmd_buf #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_cmd_buf (
        .clk     (clk),
        .Rst_n   (Rst_n),
        .wr_en   (buf_wr_s),
        .rd_en   (buf_rd_s),
        .wr_op   (cmd_op),
        .wr_amt  (cmd_amt),
        .wr_data (cmd_data),
        .full    (buf_full_s),
        .rd_op   (buf_op_s),
        .rd_amt  (buf_amt_s),
        .rd_data (buf_data_s)
    );

    // IDLE takes commands straight from the bus; while busy they park in the
    // buffer and a full buffer launches on the response handshake edge.
    always_comb begin
        start_s    = 1'b0;
        buf_wr_s   = 1'b0;
        buf_rd_s   = 1'b0;
        src_op_s   = cmd_op;
        src_amt_s  = cmd_amt;
        src_data_s = cmd_data;
        if (state_r == ST_IDLE) begin
            start_s = cmd_valid & ~buf_full_s;
        end else begin
            buf_wr_s   = cmd_valid & ~buf_full_s;
            buf_rd_s   = (state_r == ST_RESP) & rsp_ready & buf_full_s;
            start_s    = buf_rd_s;
            src_op_s   = buf_op_s;
            src_amt_s  = buf_amt_s;
            src_data_s = buf_data_s;
        end
    end

    assign cmd_ready = ~buf_full_s;
`else
    logic cmd_ready_r;

    // Commands are only taken from the bus in IDLE
    always_comb begin
        start_s    = (state_r == ST_IDLE) & cmd_valid & cmd_ready_r;
        src_op_s   = cmd_op;
        src_amt_s  = cmd_amt;
        src_data_s = cmd_data;
    end

    // Registered cmd_ready: drops on accept, rises on the response handshake
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cmd_ready_r <= 1'b1;
        end else if (start_s) begin
            cmd_ready_r <= 1'b0;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            cmd_ready_r <= 1'b1;
        end else begin
            cmd_ready_r <= cmd_ready_r;
        end
    end

    assign cmd_ready = cmd_ready_r;
`endif

    // CLEAR goes straight to the clear pulse; everything else loads first
    always_comb begin
        if (src_op_s == OP_CLEAR) begin
            launch_state_s = ST_CLR;
            launch_sel_s   = USR_HOLD;
            launch_clr_s   = 1'b1;
        end else begin
            launch_state_s = ST_LOAD;
            launch_sel_s   = USR_LOAD;
            launch_clr_s   = 1'b0;
        end
    end

    // Sequencer FSM; every register-facing output is set on the edge that
    // enters the state it belongs to, so outputs never depend on cmd_*/rsp_ready
    // combinationally.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            op_r        <= 2'b00;
            amt_r       <= '0;
            data_r      <= '0;
            usr_sel_r   <= USR_HOLD;
            usr_clr_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        op_r      <= src_op_s;
                        amt_r     <= src_amt_s;
                        data_r    <= src_data_s;
                        state_r   <= launch_state_s;
                        usr_sel_r <= launch_sel_s;
                        usr_clr_r <= launch_clr_s;
                    end else begin
                        state_r   <= ST_IDLE;
                        usr_sel_r <= USR_HOLD;
                        usr_clr_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Register takes usr_datain at this edge
                    cnt_r <= amt_r;
                    if ((op_r == OP_PASS) || (amt_r == CNT_ZERO)) begin
                        state_r     <= ST_RESP;
                        usr_sel_r   <= USR_HOLD;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        state_r   <= ST_SHIFT;
                        usr_sel_r <= shift_mode(op_r);
                    end
                end
                ST_SHIFT: begin
                    // The edge seen with cnt_r==1 applies the last step
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r <= CNT_ONE) begin
                        state_r     <= ST_RESP;
                        usr_sel_r   <= USR_HOLD;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        state_r   <= ST_SHIFT;
                        usr_sel_r <= shift_mode(op_r);
                    end
                end
                ST_CLR: begin
                    state_r     <= ST_RESP;
                    usr_clr_r   <= 1'b0;
                    usr_sel_r   <= USR_HOLD;
                    rsp_valid_r <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        if (start_s) begin
                            op_r      <= src_op_s;
                            amt_r     <= src_amt_s;
                            data_r    <= src_data_s;
                            state_r   <= launch_state_s;
                            usr_sel_r <= launch_sel_s;
                            usr_clr_r <= launch_clr_s;
                        end else begin
                            state_r   <= ST_IDLE;
                            usr_sel_r <= USR_HOLD;
                        end
                    end else begin
                        state_r     <= ST_RESP;
                        usr_sel_r   <= USR_HOLD;
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= '0;
                    usr_sel_r   <= USR_HOLD;
                    usr_clr_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign usr_sel    = usr_sel_r;
    assign usr_datain = data_r;
    assign usr_clr    = usr_clr_r;
    assign rsp_valid  = rsp_valid_r;
    // The register holds in RESP, so its contents are the result
    assign rsp_data   = usr_dataout;

endmodule

// File: tb/tb_usr_shift_controller.sv
// -----------------------------------------------------------------------------
// tb_usr_shift_controller
// Pairs usr_shift_controller with a behavioural 8-bit universal shift register
// and checks directed and random commands against a reference computed from
// plain rotate/shift arithmetic. Honours USR_SHIFT_CTRL_CMD_BUF_EN.
// -----------------------------------------------------------------------------
module tb_usr_shift_controller;

    localparam int W = 8;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         Rst_n;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [A-1:0] cmd_amt = '0;
    logic [W-1:0] cmd_data = '0;
    logic [1:0]   usr_sel;
    logic [W-1:0] usr_datain;
    logic         usr_clr;
    logic [W-1:0] usr_dataout;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    usr_shift_controller #(.WIDTH(W), .AMT_W(A)) dut (
        .clk         (clk),
        .Rst_n       (Rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_amt     (cmd_amt),
        .cmd_data    (cmd_data),
        .usr_sel     (usr_sel),
        .usr_datain  (usr_datain),
        .usr_clr     (usr_clr),
        .usr_dataout (usr_dataout),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data)
    );

    // Behavioural universal shift register driven by the controller
    logic [W-1:0] usr_q = '0;
    assign usr_dataout = usr_q;

    always_ff @(posedge clk) begin
        if (usr_clr) usr_q <= '0;
        else begin
            case (usr_sel)
                2'b01:   usr_q <= {usr_q[0], usr_q[W-1:1]};
                2'b10:   usr_q <= {usr_q[W-2:0], 1'b0};
                2'b11:   usr_q <= usr_datain;
                default: usr_q <= usr_q;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected result straight from the command semantics
    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input int amt, input logic [W-1:0] d);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        dd = {d, d} >> amt;
        case (op)
            2'b00:   r = dd[W-1:0];
            2'b01:   r = (amt >= W) ? '0 : (d << amt);
            2'b10:   r = d;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Issue one command, follow it to its response, apply bp cycles of back-pressure
    task automatic run_cmd(input logic [1:0] op, input int amt, input logic [W-1:0] d, input int bp);
        int n, k, shifts, loads, clrs, exp_lat, exp_shifts;
        logic [W-1:0] exp_d, held;
        exp_d      = ref_result(op, amt, d);
        exp_shifts = (op == 2'b00 || op == 2'b01) ? amt : 0;
        exp_lat    = 2 + exp_shifts;
        n = 0;
        while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
        check_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt[A-1:0]; cmd_data = d; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
`ifdef USR_SHIFT_CTRL_CMD_BUF_EN
        check_eq("cmd_ready_busy", cmd_ready, 1);
`else
        check_eq("cmd_ready_busy", cmd_ready, 0);
`endif
        k = 1; shifts = 0; loads = 0; clrs = 0;
        while (k < 40) begin
            if (rsp_valid) break;
            if (usr_sel == 2'b01 || usr_sel == 2'b10) shifts++;
            if (usr_sel == 2'b11) loads++;
            if (usr_clr) clrs++;
            @(negedge clk);
            k++;
        end
        check_eq("rsp_arrives", rsp_valid, 1);
        if (!rsp_valid) return;
        check_eq("latency", k, exp_lat);
        check_eq("shift_steps", shifts, exp_shifts);
        check_eq("load_cycles", loads, (op == 2'b11) ? 0 : 1);
        check_eq("clr_cycles", clrs, (op == 2'b11) ? 1 : 0);
        check_eq("rsp_data", rsp_data, exp_d);
        check_eq("resp_hold_sel", usr_sel, 2'b00);
        held = rsp_data;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_eq("bp_valid", rsp_valid, 1);
            check_eq("bp_data", rsp_data, held);
            check_eq("bp_sel", usr_sel, 2'b00);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("single_handshake", rsp_valid, 0);
    endtask

    initial begin
        int highs, sels;
        Rst_n = 1'b1;
        #2 Rst_n = 1'b0;
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_usr_sel", usr_sel, 2'b00);
        check_eq("rst_usr_datain", usr_datain, 0);
        check_eq("rst_usr_clr", usr_clr, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        Rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_cmd(2'b00, 3, 8'hB4, 0);   // ROR -> 96
        check_eq("ror_b4_const", usr_dataout, 8'h96);
        run_cmd(2'b01, 2, 8'hC3, 4);   // SLL with back-pressure -> 0C
        check_eq("sll_c3_const", usr_dataout, 8'h0C);
        run_cmd(2'b10, 0, 8'h5A, 0);   // PASS
        run_cmd(2'b00, 0, 8'hA5, 0);   // ROR by 0
        run_cmd(2'b10, 0, 8'hFF, 0);   // load all ones
        run_cmd(2'b11, 0, 8'h00, 1);   // CLEAR
        check_eq("clear_const", usr_dataout, 8'h00);
        run_cmd(2'b00, 7, 8'h81, 0);   // ROR 7 == ROL 1 -> 03
        check_eq("ror7_const", usr_dataout, 8'h03);
        run_cmd(2'b01, 7, 8'hFF, 2);   // SLL max -> 80

        // Random commands
        for (int i = 0; i < 25; i++) begin
            run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    8'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a long rotate
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_amt = 3'd7; cmd_data = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre_reset_shift", usr_sel, 2'b01);
        Rst_n = 1'b0;
        #1;
        check_eq("midrst_usr_sel", usr_sel, 2'b00);
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        check_eq("midrst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        Rst_n = 1'b1;
        highs = 0; sels = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid) highs++;
            if (usr_sel != 2'b00) sels++;
        end
        rsp_ready = 1'b0;
        check_eq("no_rsp_after_reset", highs, 0);
        check_eq("no_sel_after_reset", sels, 0);
        run_cmd(2'b01, 1, 8'h81, 0);   // recovers after reset -> 02

`ifdef USR_SHIFT_CTRL_CMD_BUF_EN
        begin
            int got;
            logic prev_v;
            logic [W-1:0] r0, r1;
            got = 0; prev_v = 1'b0; r0 = '0; r1 = '0;
            rsp_ready = 1'b1;
            cmd_valid = 1'b1; cmd_op = 2'b00; cmd_amt = 3'd1; cmd_data = 8'h01;
            @(posedge clk);
            @(negedge clk);
            check_eq("buf_ready_second", cmd_ready, 1);
            cmd_op = 2'b01; cmd_amt = 3'd1; cmd_data = 8'h81;
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            check_eq("buf_full_ready", cmd_ready, 0);
            for (int i = 0; i < 30; i++) begin
                if (prev_v && got == 1) begin
                    check_eq("b2b_load", usr_sel, 2'b11);
                    check_eq("buf_drained_ready", cmd_ready, 1);
                end
                prev_v = rsp_valid;
                if (rsp_valid) begin
                    if (got == 0) r0 = rsp_data; else r1 = rsp_data;
                    got++;
                    if (got == 2) break;
                end
                @(negedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            check_eq("buf_rsp_count", got, 2);
            check_eq("buf_rsp0", r0, 8'h80);
            check_eq("buf_rsp1", r1, 8'h02);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
